// File: rtl/audio_i2s_tx.sv
// I2S transmitter: one-deep sample holding register, mono sample sent on
// both channels, BCLK derived from clk, per-frame request strobe and
// sticky underrun/overrun flags.
module audio_i2s_tx #(
  parameter int unsigned SIG_BITS = 16,
  parameter int unsigned CLK_DIV  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SIG_BITS-1:0] in,
  input  logic                valid,
  input  logic                clr_flags,
  output logic                req,
  output logic                underrun,
  output logic                overrun,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(2 * SIG_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SIG_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_R   = BIT_W'(SIG_BITS);

  logic [DIV_W-1:0]    div_cnt, div_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_nxt;
  logic [SIG_BITS-1:0] hold, hold_nxt;
  logic                full, full_nxt;
  logic [SIG_BITS-1:0] word, word_nxt;
  logic [SIG_BITS-1:0] shift, shift_nxt;
  logic                bclk_nxt, lrclk_nxt, sdata_nxt, req_nxt;
  logic                under_nxt, over_nxt;
  logic                fall, frame_start, under_set, over_set;

  // Next-state: divider, bit counter, frame load, serialiser, holding register, flags
  always_comb begin
    div_nxt     = div_cnt + 1'b1;
    bclk_nxt    = bclk;
    bit_nxt     = bit_cnt;
    lrclk_nxt   = lrclk;
    sdata_nxt   = sdata;
    word_nxt    = word;
    shift_nxt   = shift;
    hold_nxt    = hold;
    full_nxt    = full;
    req_nxt     = 1'b0;
    under_set   = 1'b0;
    over_set    = 1'b0;
    fall        = 1'b0;
    frame_start = 1'b0;

    if (div_cnt == DIV_LAST) begin
      div_nxt  = '0;
      bclk_nxt = ~bclk;
      fall     = bclk;
    end

    if (fall) begin
      bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      lrclk_nxt = (bit_nxt >= SLOT_R);
      if (bit_nxt == '0) begin
        // Slot 0 still carries the previous right word's LSB.
        frame_start = 1'b1;
        req_nxt     = 1'b1;
        sdata_nxt   = word[0];
        if (full) begin
          word_nxt  = hold;
          shift_nxt = hold;
          full_nxt  = 1'b0;
        end else begin
          shift_nxt = word;
          under_set = 1'b1;
        end
      end else begin
        sdata_nxt = shift[SIG_BITS-1];
        // After the left LSB goes out, restart the shifter for the right word.
        shift_nxt = (bit_nxt == SLOT_R) ? word : {shift[SIG_BITS-2:0], 1'b0};
      end
    end

    // A write on the frame-start cycle lands after the load, so it never overruns.
    if (valid) begin
      hold_nxt = in;
      full_nxt = 1'b1;
      over_set = full && !frame_start;
    end

    under_nxt = under_set | (underrun & ~clr_flags);
    over_nxt  = over_set  | (overrun  & ~clr_flags);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      bclk     <= 1'b0;
      bit_cnt  <= BIT_LAST;
      lrclk    <= 1'b1;
      sdata    <= 1'b0;
      req      <= 1'b0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
      hold     <= '0;
      full     <= 1'b0;
      word     <= '0;
      shift    <= '0;
    end else begin
      div_cnt  <= div_nxt;
      bclk     <= bclk_nxt;
      bit_cnt  <= bit_nxt;
      lrclk    <= lrclk_nxt;
      sdata    <= sdata_nxt;
      req      <= req_nxt;
      underrun <= under_nxt;
      overrun  <= over_nxt;
      hold     <= hold_nxt;
      full     <= full_nxt;
      word     <= word_nxt;
      shift    <= shift_nxt;
    end
  end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Transmit end of the theremin audio sample path. Accepts 16-bit samples from the effect chain (the `out`/`valid` stream of the delay stage) through a one-deep holding register. Serialises them as a standard I2S stream (BCLK, LRCLK, SDATA) for the audio DAC, with the mono sample duplicated to left and right. It paces the chain with a per-frame request strobe and reports underrun and overrun.

## Interface
- `SIG_BITS`, 16: sample width; also the slot width (BCLK periods per channel).
- `CLK_DIV`, 16: `clk` cycles per BCLK half-period; minimum 2. At 50 MHz this gives BCLK = 1.5625 MHz and fs = 48.828 kHz.
- `clk`  in  1: system clock. One clock domain only.
- `reset`  in  1: synchronous, active-high reset.
- `in`  in  SIG_BITS: sample, two's complement.
- `valid`  in  1: one-cycle strobe; `in` is captured on the cycle it is high.
- `clr_flags`  in  1: synchronous clear of the `underrun` and `overrun` flags.
- `req`  out  1: one-cycle pulse; the holding register has been consumed, so the next sample may be sent.
- `underrun`  out  1: sticky; a frame started with the holding register empty.
- `overrun`  out  1: sticky; `valid` arrived while the holding register was full.
- `bclk`  out  1: I2S bit clock, a registered output.
- `lrclk`  out  1: I2S word select; 0 = left, 1 = right.
- `sdata`  out  1: I2S serial data, MSB first.

## Operation
- Divider
  - `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - When it wraps, `bclk` toggles.
  - A 1→0 toggle of `bclk` is a *fall event*; every output change other than `bclk` happens only on fall events.
- Bit counter
  - `bit_cnt` runs over 0..2·SIG_BITS-1 and increments on each fall event, wrapping to 0.
  - Reset value is 2·SIG_BITS-1, so the first fall event starts a frame.
  - On each fall event: `lrclk` = (new `bit_cnt` ≥ SIG_BITS).
- Frame start (fall event with new `bit_cnt` = 0)
  - If the holding register is full: load its sample S into both the left and right words, mark it empty, and pulse `req`.
  - If it is empty: reload the last transmitted sample and set `underrun`. `req` is still pulsed.
- Data (I2S one-bit delay)
  - At slot k = 0: `sdata` is the LSB of the previous frame's right word.
  - At slots k = 1..SIG_BITS: `sdata` is left bit SIG_BITS-k (MSB first).
  - At slot k = SIG_BITS: the right word starts; `sdata` is the left LSB.
  - At slots k = SIG_BITS+1..2·SIG_BITS-1: `sdata` is right bits from the MSB downward.
  - The right LSB is sent at slot 0 of the next frame.
- Holding register
  - `valid` writes `in` and marks the register full.
  - If it was already full, the new sample overwrites the old one and `overrun` is set.
- Simultaneous valid and frame start
  - The frame-start load uses the holding state from before the cycle.
  - The new sample is then written and the register is full afterwards.
  - If the register was empty, `underrun` is set and the sample waits for the next frame.
  - `overrun` is not set in this case.
- Flags
  - `underrun` and `overrun` are set-dominant over `clr_flags` in the same cycle.
  - They are cleared only by `reset` or `clr_flags`.
- Reset mid-frame: takes effect on the next edge. Every register returns to its reset value; the partial frame is abandoned, with no completion.

## Timing
- Reset values
  - `bclk` = 0, `lrclk` = 1, `sdata` = 0.
  - `req`, `underrun` and `overrun` = 0.
  - Holding register empty; last sample = 0; `div_cnt` = 0.
- `bclk` edges
  - First rise: CLK_DIV cycles after reset deasserts.
  - First fall (frame start): 2·CLK_DIV cycles after reset deasserts.
- At the first fall event: `lrclk` goes to 0 and `req` pulses for one cycle, registered in the same cycle as the `bclk` fall.
- Frame period: 4·SIG_BITS·CLK_DIV `clk` cycles (1024 at the defaults). There is exactly one `req` per frame.
- `sdata` and `lrclk` are stable from one fall event to the next. The DAC samples them on `bclk` rise, CLK_DIV cycles after the change.
- Latency from capture to MSB on the wire: the MSB appears one fall event after the frame start that loads the sample.

## Test plan
- Reset check: hold `reset` for 5 cycles, then release.
  - During reset: all outputs at their reset values.
  - After release: first `bclk` rise at cycle 16, first fall at cycle 32, `lrclk` 0 and `req` pulsing at the fall.
- Single sample: send `valid` with `in`=16'hA5C3 before the first frame.
  - The DAC model samples on `bclk` rise and decodes L = R = 16'hA5C3.
  - `lrclk` has a period of 1024 cycles with 50% duty.
- Underrun: send no samples for 3 frames after sending 16'h1234.
  - Frames 2 and 3 repeat 16'h1234.
  - `underrun` is set at the frame-2 start and holds until `clr_flags`.
- Overrun: send `valid` with 16'h0001, then 16'h0002, inside one frame.
  - `overrun` is set on the second write.
  - The next frame transmits 16'h0002.
- Simultaneous events: assert `valid` (16'h7FFF) on the exact frame-start cycle with the register empty.
  - Underrun is set and the current frame repeats the last sample.
  - The next frame sends 16'h7FFF.
  - No overrun is flagged.
- Reset mid-frame: assert `reset` at bit 7 of the left slot.
  - Outputs return to their reset values on the next cycle.
  - After release, timing restarts exactly as in the reset-check scenario.
